// File: rtl/hwpe_ctrl_job_offloader.sv
// Bus initiator that launches an HWPE job: ACQUIRE read with retry, parameter writes,
// TRIGGER write, then waits for the completion event.
module hwpe_ctrl_job_offloader #(
    parameter logic [31:0] BASE_ADDR      = 32'h0,
    parameter int          N_PARAMS       = 16,
    parameter int          PARAM_BASE_IDX = 8,
    parameter int          RETRY_GAP      = 4,
    parameter int          ID_WIDTH       = 8,
    localparam int         IDX_W          = (N_PARAMS > 1) ? $clog2(N_PARAMS) : 1,
    localparam int         CNT_W          = $clog2(N_PARAMS + 1)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                prm_we_i,
    input  logic [IDX_W-1:0]    prm_idx_i,
    input  logic [31:0]         prm_data_i,
    input  logic                start_i,
    input  logic [CNT_W-1:0]    n_params_i,
    input  logic                evt_i,
    output logic                per_req_o,
    input  logic                per_gnt_i,
    output logic [31:0]         per_add_o,
    output logic                per_wen_o,
    output logic [3:0]          per_be_o,
    output logic [31:0]         per_data_o,
    output logic [ID_WIDTH-1:0] per_id_o,
    input  logic                per_r_valid_i,
    input  logic [31:0]         per_r_data_i,
    output logic                busy_o,
    output logic [7:0]          job_id_o,
    output logic                done_o
);

    localparam int GAP_W = (RETRY_GAP > 1) ? $clog2(RETRY_GAP + 1) : 1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ACQ  = 3'd1,
        ST_GAP  = 3'd2,
        ST_PRM  = 3'd3,
        ST_TRIG = 3'd4,
        ST_WAIT = 3'd5
    } state_e;

    state_e           state_r;
    logic             req_r;
    logic             pend_r;
    logic [31:0]      add_r;
    logic             wen_r;
    logic [31:0]      data_r;
    logic             busy_r;
    logic [7:0]       job_id_r;
    logic             done_r;
    logic [CNT_W-1:0] n_r;
    logic [CNT_W-1:0] cnt_r;
    logic [GAP_W-1:0] gap_r;
    logic [31:0]      prm_buf_r [N_PARAMS];

    logic             rsp_s;
    logic [CNT_W-1:0] n_sat_s;
    logic [CNT_W-1:0] nxt_cnt_s;
    logic             unused_rdata_s;

    assign rsp_s          = pend_r & per_r_valid_i;
    assign n_sat_s        = (n_params_i > CNT_W'(N_PARAMS)) ? CNT_W'(N_PARAMS) : n_params_i;
    assign nxt_cnt_s      = cnt_r + CNT_W'(1);
    assign unused_rdata_s = ^per_r_data_i[30:8];

    function automatic logic [31:0] prm_addr(input logic [CNT_W-1:0] k);
        logic [31:0] idx;
        idx      = 32'(PARAM_BASE_IDX) + 32'(k);
        prm_addr = BASE_ADDR + {idx[29:0], 2'b00};
    endfunction

    // Local parameter buffer; contents are only meaningful once written.
    always_ff @(posedge clk_i) begin
        if (prm_we_i && !busy_r) begin
            prm_buf_r[prm_idx_i] <= prm_data_i;
        end
    end

    // Job sequencer: bus handshake tracking plus the offload state machine.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r  <= ST_IDLE;
            req_r    <= 1'b0;
            pend_r   <= 1'b0;
            add_r    <= 32'h0;
            wen_r    <= 1'b1;
            data_r   <= 32'h0;
            busy_r   <= 1'b0;
            job_id_r <= 8'h0;
            done_r   <= 1'b0;
            n_r      <= {CNT_W{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
            gap_r    <= {GAP_W{1'b0}};
        end else begin
            done_r <= 1'b0;
            // Single outstanding transaction: req -> gnt -> wait for r_valid.
            if (req_r && per_gnt_i) begin
                req_r  <= 1'b0;
                pend_r <= 1'b1;
            end else if (rsp_s) begin
                pend_r <= 1'b0;
            end
            case (state_r)
                ST_IDLE: begin
                    if (start_i) begin
                        state_r <= ST_ACQ;
                        busy_r  <= 1'b1;
                        n_r     <= n_sat_s;
                        cnt_r   <= {CNT_W{1'b0}};
                        req_r   <= 1'b0;
                        pend_r  <= 1'b0;
                    end
                end
                ST_ACQ: begin
                    if (!req_r && !pend_r) begin
                        req_r  <= 1'b1;
                        add_r  <= BASE_ADDR + 32'h4;
                        wen_r  <= 1'b1;
                        data_r <= 32'h0;
                    end else if (rsp_s) begin
                        if (per_r_data_i[31]) begin
                            state_r <= ST_GAP;
                            gap_r   <= {GAP_W{1'b0}};
                        end else begin
                            job_id_r <= per_r_data_i[7:0];
                            req_r    <= 1'b1;
                            wen_r    <= 1'b0;
                            if (n_r == {CNT_W{1'b0}}) begin
                                state_r <= ST_TRIG;
                                add_r   <= BASE_ADDR;
                                data_r  <= 32'h0;
                            end else begin
                                state_r <= ST_PRM;
                                add_r   <= prm_addr({CNT_W{1'b0}});
                                data_r  <= prm_buf_r[{IDX_W{1'b0}}];
                            end
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_r == GAP_W'(RETRY_GAP - 1)) begin
                        state_r <= ST_ACQ;
                    end else begin
                        gap_r <= gap_r + GAP_W'(1);
                    end
                end
                ST_PRM: begin
                    // Next write is issued on the same edge as the previous response.
                    if (rsp_s) begin
                        req_r <= 1'b1;
                        if (cnt_r == n_r - CNT_W'(1)) begin
                            state_r <= ST_TRIG;
                            add_r   <= BASE_ADDR;
                            data_r  <= 32'h0;
                        end else begin
                            cnt_r  <= nxt_cnt_s;
                            add_r  <= prm_addr(nxt_cnt_s);
                            data_r <= prm_buf_r[nxt_cnt_s[IDX_W-1:0]];
                        end
                    end
                end
                ST_TRIG: begin
                    if (rsp_s) begin
                        state_r <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (evt_i) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    req_r   <= 1'b0;
                    pend_r  <= 1'b0;
                end
            endcase
        end
    end

    assign per_req_o  = req_r;
    assign per_add_o  = add_r;
    assign per_wen_o  = wen_r;
    assign per_be_o   = 4'hF;
    assign per_data_o = data_r;
    assign per_id_o   = {ID_WIDTH{1'b0}};
    assign busy_o     = busy_r;
    assign job_id_o   = job_id_r;
    assign done_o     = done_r;

endmodule
